// File: rtl/univ_shift_burst_pkg.sv
// Shared types for the universal shift/burst register: step modes and FSM states.
package usrb_pkg;

    typedef enum logic [2:0] {
        SHL  = 3'b000,
        SHR  = 3'b001,
        ROL  = 3'b010,
        ROR  = 3'b011,
        ASR  = 3'b100,
        HOLD = 3'b101
    } usrb_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } usrb_state_t;

endpackage

// File: rtl/univ_shift_burst_if.sv
// Control/data bundle for univ_shift_burst; the parity signal exists only with USRB_PARITY_EN.
interface univ_shift_burst_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 4
);
    logic [2:0]       mode;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [LANES-1:0] sin;
    logic [WIDTH-1:0] out;
    logic [LANES-1:0] sout_l;
    logic [LANES-1:0] sout_r;
    logic             busy;
    logic             done;
`ifdef USRB_PARITY_EN
    logic             parity;
`endif

    modport master (
        output mode, en, load, load_data, start, count, sin,
        input  out, sout_l, sout_r, busy, done
`ifdef USRB_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  mode, en, load, load_data, start, count, sin,
        output out, sout_l, sout_r, busy, done
`ifdef USRB_PARITY_EN
        , output parity
`endif
    );

endinterface

// File: rtl/univ_shift_burst_step.sv
// Combinational one-step next-value shifter shared by the manual and burst paths.
module usrb_step
    import usrb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input  logic [WIDTH-1:0] cur,
    input  usrb_mode_t       mode,
    input  logic [LANES-1:0] sin,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            SHL:     nxt = {cur[WIDTH-LANES-1:0], sin};
            SHR:     nxt = {sin, cur[WIDTH-1:LANES]};
            ROL:     nxt = {cur[WIDTH-LANES-1:0], cur[WIDTH-1 -: LANES]};
            ROR:     nxt = {cur[LANES-1:0], cur[WIDTH-1:LANES]};
            ASR:     nxt = {{LANES{cur[WIDTH-1]}}, cur[WIDTH-1:LANES]};
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/univ_shift_burst.sv
// Universal shift register with parallel load and N-step burst engine (busy/done).
// Optional registered parity output enabled by defining USRB_PARITY_EN.
module univ_shift_burst
    import usrb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    univ_shift_burst_if.slave bus
);

    usrb_state_t      state;
    usrb_mode_t       mode_q;
    usrb_mode_t       step_mode;
    logic [CNT_W-1:0] rem_q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] nxt;
    logic             busy_q;
    logic             done_q;

    usrb_step #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_step (
        .cur  (r),
        .mode (step_mode),
        .sin  (bus.sin),
        .nxt  (nxt)
    );

    // Next register value resolved here so parity can track it on the same edge.
    always_comb begin
        step_mode = (state == BURST) ? mode_q : usrb_mode_t'(bus.mode);
        r_d       = r;
        if (state == BURST)
            r_d = nxt;
        else if (bus.load)
            r_d = bus.load_data;
        else if (!bus.start && bus.en)
            r_d = nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            mode_q <= HOLD;
            rem_q  <= '0;
            r      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            r      <= r_d;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.load && bus.start) begin
                        if (bus.count != '0) begin
                            mode_q <= usrb_mode_t'(bus.mode);
                            rem_q  <= bus.count;
                            busy_q <= 1'b1;
                            state  <= BURST;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef USRB_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rstn)
            parity_q <= 1'b0;
        else
            parity_q <= ^r_d;
    end

    assign bus.parity = parity_q;
`endif

    assign bus.out    = r;
    assign bus.sout_l = r[WIDTH-1 -: LANES];
    assign bus.sout_r = r[LANES-1:0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_univ_shift_burst.sv
// Randomized self-checking bench: two DUTs (LANES=1 and LANES=2) share control stimulus.
module tb_univ_shift_burst;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] mode;
    logic       en, load, start;
    logic [7:0] load_data;
    logic [3:0] count;
    logic       sin1;
    logic [1:0] sin2;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    // Reference model state
    int unsigned mv1, mv2, mleft, mmode;
    bit          mbusy, mdone;

    always #5 clk = ~clk;

    univ_shift_burst_if #(.WIDTH(8), .LANES(1), .CNT_W(4)) b1 ();
    univ_shift_burst_if #(.WIDTH(8), .LANES(2), .CNT_W(4)) b2 ();

    assign b1.mode = mode;  assign b2.mode = mode;
    assign b1.en = en;      assign b2.en = en;
    assign b1.load = load;  assign b2.load = load;
    assign b1.load_data = load_data; assign b2.load_data = load_data;
    assign b1.start = start; assign b2.start = start;
    assign b1.count = count; assign b2.count = count;
    assign b1.sin = sin1;   assign b2.sin = sin2;

    univ_shift_burst #(.WIDTH(8), .LANES(1), .CNT_W(4)) u1 (.clk(clk), .rstn(rstn), .bus(b1.slave));
    univ_shift_burst #(.WIDTH(8), .LANES(2), .CNT_W(4)) u2 (.clk(clk), .rstn(rstn), .bus(b2.slave));

    function automatic int unsigned stepf(int unsigned v, int unsigned m, int unsigned s, int unsigned l);
        int unsigned hi;
        hi = 255 ^ (255 >> l);
        case (m)
            0: return ((v << l) | s) & 255;
            1: return (v >> l) | (s << (8 - l));
            2: return ((v << l) | (v >> (8 - l))) & 255;
            3: return ((v >> l) | (v << (8 - l))) & 255;
            4: return (v >> l) | ((((v >> 7) & 1) != 0) ? hi : 0);
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        bit nd;
        if (!rstn) begin
            mv1 = 0; mv2 = 0; mbusy = 0; mdone = 0; mleft = 0;
        end else begin
            nd = 0;
            if (mbusy) begin
                mv1 = stepf(mv1, mmode, sin1, 1);
                mv2 = stepf(mv2, mmode, sin2, 2);
                mleft--;
                if (mleft == 0) begin mbusy = 0; nd = 1; end
            end else if (load) begin
                mv1 = load_data; mv2 = load_data;
            end else if (start) begin
                if (count != 0) begin mbusy = 1; mleft = count; mmode = mode; end
                else nd = 1;
            end else if (en) begin
                mv1 = stepf(mv1, mode, sin1, 1);
                mv2 = stepf(mv2, mode, sin2, 2);
            end
            mdone = nd;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; load = 0; start = 0; count = 0; mode = 0; sin1 = 0; sin2 = 0; load_data = 0;
    endtask

    task automatic test_reset();
        rstn = 0; idle_inputs(); load_data = 8'hA5; load = 1;
        tick(); tick();
        nvec++; if (b1.out !== 8'h00) begin nmis++; $display("FAIL reset_out got=%h exp=00", b1.out); end
        nvec++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin nmis++; $display("FAIL reset_flags got busy=%b done=%b exp 0/0", b1.busy, b1.done); end
        rstn = 1;
        tick();
        load = 0;
        nvec++; if (b1.out !== 8'hA5) begin nmis++; $display("FAIL load_out1 got=%h exp=a5", b1.out); end
        nvec++; if (b2.out !== 8'hA5) begin nmis++; $display("FAIL load_out2 got=%h exp=a5", b2.out); end
        nvec++; if (b2.busy !== 1'b0 || b2.done !== 1'b0) begin nmis++; $display("FAIL load_flags got busy=%b done=%b exp 0/0", b2.busy, b2.done); end
    endtask

    task automatic test_manual();
        logic [2:0] mt [3] = '{3'd0, 3'd3, 3'd4};
        logic [7:0] et [3] = '{8'h02, 8'hC0, 8'hC0};
        for (int i = 0; i < 3; i++) begin
            load = 1; load_data = 8'h81; tick(); load = 0;
            mode = mt[i]; en = 1; sin1 = 0; sin2 = 0; tick(); en = 0;
            nvec++; if (b1.out !== et[i]) begin nmis++; $display("FAIL manual_l1 mode=%0d got=%h exp=%h", mt[i], b1.out, et[i]); end
            nvec++; if (b2.out !== mv2[7:0]) begin nmis++; $display("FAIL manual_l2 mode=%0d got=%h exp=%h", mt[i], b2.out, mv2[7:0]); end
        end
    endtask

    task automatic test_burst();
        int  nb;
        bit  seen;
        load = 1; load_data = 8'h00; tick(); load = 0;
        mode = 3'd0; count = 4'd3; sin1 = 1; sin2 = 2'b11; start = 1; tick(); start = 0;
        nb = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (b2.busy === 1'b1) nb++;
            if (b2.done === 1'b1) begin seen = 1; break; end
            tick();
        end
        nvec++; if (!seen) begin nmis++; $display("FAIL burst_done_timeout got=none exp=pulse"); end
        nvec++; if (nb != 3) begin nmis++; $display("FAIL burst_busy_cycles got=%0d exp=3", nb); end
        nvec++; if (b2.out !== 8'h3F) begin nmis++; $display("FAIL burst_out2 got=%h exp=3f", b2.out); end
        nvec++; if (b2.busy !== 1'b0) begin nmis++; $display("FAIL burst_busy_fall got=%b exp=0", b2.busy); end
        nvec++; if (b1.out !== mv1[7:0]) begin nmis++; $display("FAIL burst_out1 got=%h exp=%h", b1.out, mv1[7:0]); end
        tick();
        nvec++; if (b2.done !== 1'b0) begin nmis++; $display("FAIL burst_done_width got=%b exp=0", b2.done); end
    endtask

    task automatic test_corner();
        // count=0: done pulse, no shift, busy stays low
        load = 1; load_data = 8'h96; tick(); load = 0;
        mode = 3'd0; sin1 = 1; sin2 = 3; count = 0; start = 1; tick(); start = 0;
        nvec++; if (b1.done !== 1'b1 || b1.busy !== 1'b0) begin nmis++; $display("FAIL zero_count got done=%b busy=%b exp 1/0", b1.done, b1.busy); end
        nvec++; if (b1.out !== 8'h96 || b2.out !== 8'h96) begin nmis++; $display("FAIL zero_count_out got=%h/%h exp=96", b1.out, b2.out); end
        tick();
        nvec++; if (b1.done !== 1'b0) begin nmis++; $display("FAIL zero_count_done_width got=%b exp=0", b1.done); end
        // load wins over start
        load = 1; load_data = 8'h5A; start = 1; count = 5; tick(); load = 0; start = 0;
        nvec++; if (b1.out !== 8'h5A || b1.busy !== 1'b0) begin nmis++; $display("FAIL load_vs_start got out=%h busy=%b exp 5a/0", b1.out, b1.busy); end
        // en and live mode toggled mid-burst are ignored
        load = 1; load_data = 8'h3C; tick(); load = 0;
        mode = 3'd0; count = 4; start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            en = i[0]; mode = 3'd3; sin1 = 1'($urandom); sin2 = 2'($urandom);
            tick();
            nvec++; if (b1.out !== mv1[7:0] || b2.out !== mv2[7:0]) begin nmis++; $display("FAIL en_in_burst step=%0d got=%h/%h exp=%h/%h", i, b1.out, b2.out, mv1[7:0], mv2[7:0]); end
        end
        en = 0;
        nvec++; if (b1.done !== 1'b1) begin nmis++; $display("FAIL en_in_burst_done got=%b exp=1", b1.done); end
        tick();
    endtask

    task automatic test_back_to_back();
        int nb;
        bit seen;
        load = 1; load_data = 8'hC3; tick(); load = 0;
        mode = 3'd2; count = 2; start = 1; tick(); start = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (b1.done === 1'b1) begin seen = 1; break; end
            tick();
        end
        nvec++; if (!seen) begin nmis++; $display("FAIL b2b_first_timeout got=none exp=pulse"); end
        mode = 3'd1; count = 3; start = 1; sin1 = 1; sin2 = 2; tick(); start = 0;
        nvec++; if (b1.busy !== 1'b1 || b1.done !== 1'b0) begin nmis++; $display("FAIL b2b_restart got busy=%b done=%b exp 1/0", b1.busy, b1.done); end
        nb = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (b1.busy === 1'b1) nb++;
            if (b1.done === 1'b1) begin seen = 1; break; end
            sin1 = 1'($urandom); sin2 = 2'($urandom);
            tick();
        end
        nvec++; if (!seen || nb != 3) begin nmis++; $display("FAIL b2b_second got busy_cycles=%0d done_seen=%0d exp 3/1", nb, seen); end
        nvec++; if (b1.out !== mv1[7:0] || b2.out !== mv2[7:0]) begin nmis++; $display("FAIL b2b_out got=%h/%h exp=%h/%h", b1.out, b2.out, mv1[7:0], mv2[7:0]); end
        tick();
    endtask

    task automatic test_reset_mid();
        int nd;
        load = 1; load_data = 8'hFF; tick(); load = 0;
        mode = 3'd1; sin1 = 1; sin2 = 3; count = 10; start = 1; tick(); start = 0;
        tick(); tick(); tick();
        rstn = 0; tick(); rstn = 1;
        nvec++; if (b1.out !== 8'h00 || b2.out !== 8'h00) begin nmis++; $display("FAIL rst_mid_out got=%h/%h exp=00", b1.out, b2.out); end
        nvec++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin nmis++; $display("FAIL rst_mid_flags got busy=%b done=%b exp 0/0", b1.busy, b1.done); end
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b1.done === 1'b1 || b2.done === 1'b1) nd++;
        end
        nvec++; if (nd != 0) begin nmis++; $display("FAIL rst_mid_no_done got=%0d pulses exp=0", nd); end
    endtask

`ifdef USRB_PARITY_EN
    task automatic test_parity();
        load = 1; load_data = 8'h07; tick(); load = 0;
        nvec++; if (b1.parity !== 1'b1) begin nmis++; $display("FAIL parity_07 got=%b exp=1", b1.parity); end
        mode = 3'd2; en = 1; tick(); en = 0;
        nvec++; if (b1.parity !== 1'b1 || b1.out !== 8'h0E) begin nmis++; $display("FAIL parity_rol got=%b out=%h exp 1/0e", b1.parity, b1.out); end
        load = 1; load_data = 8'h03; tick(); load = 0;
        nvec++; if (b1.parity !== 1'b0) begin nmis++; $display("FAIL parity_03 got=%b exp=0", b1.parity); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rstn      = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            load      = ($urandom_range(0, 9) == 0);
            start     = ($urandom_range(0, 6) == 0);
            en        = 1'($urandom);
            mode      = 3'($urandom);
            count     = 4'($urandom_range(0, 6));
            load_data = 8'($urandom);
            sin1      = 1'($urandom);
            sin2      = 2'($urandom);
            tick();
            nvec++; if (b1.out !== mv1[7:0]) begin nmis++; $display("FAIL rnd_out1 cyc=%0d got=%h exp=%h", c, b1.out, mv1[7:0]); end
            nvec++; if (b2.out !== mv2[7:0]) begin nmis++; $display("FAIL rnd_out2 cyc=%0d got=%h exp=%h", c, b2.out, mv2[7:0]); end
            nvec++; if (b1.busy !== mbusy || b2.busy !== mbusy) begin nmis++; $display("FAIL rnd_busy cyc=%0d got=%b/%b exp=%b", c, b1.busy, b2.busy, mbusy); end
            nvec++; if (b1.done !== mdone || b2.done !== mdone) begin nmis++; $display("FAIL rnd_done cyc=%0d got=%b/%b exp=%b", c, b1.done, b2.done, mdone); end
            nvec++; if (b2.sout_l !== mv2[7:6] || b2.sout_r !== mv2[1:0]) begin nmis++; $display("FAIL rnd_sout2 cyc=%0d got=%b/%b exp=%b/%b", c, b2.sout_l, b2.sout_r, mv2[7:6], mv2[1:0]); end
            nvec++; if (b1.sout_l !== mv1[7] || b1.sout_r !== mv1[0]) begin nmis++; $display("FAIL rnd_sout1 cyc=%0d got=%b/%b exp=%b/%b", c, b1.sout_l, b1.sout_r, mv1[7], mv1[0]); end
`ifdef USRB_PARITY_EN
            nvec++; if (b1.parity !== (^mv1[7:0]) || b2.parity !== (^mv2[7:0])) begin nmis++; $display("FAIL rnd_parity cyc=%0d got=%b/%b exp=%b/%b", c, b1.parity, b2.parity, ^mv1[7:0], ^mv2[7:0]); end
`endif
        end
        rstn = 1; idle_inputs();
        for (int i = 0; i < 20; i++) tick();
    endtask

    initial begin
        mv1 = 0; mv2 = 0; mleft = 0; mmode = 0; mbusy = 0; mdone = 0;
        test_reset();
        test_manual();
        test_burst();
        test_corner();
        test_back_to_back();
        test_reset_mid();
`ifdef USRB_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/univ_shift_burst.md
Name: univ_shift_burst

Overview:
Parametrised universal shift register for the sequential-circuits library, and the successor of the single-bit bidirectional shifter. It adds:
- multi-lane shifting (LANES bits per step)
- rotate and arithmetic modes
- parallel load
- a burst engine that performs N back-to-back shifts from a single start request, with a busy/done handshake

It sits between serial links and parallel datapaths as a SERDES-style staging register.

Parameters:
- WIDTH, 8: register width in bits; must satisfy WIDTH >= 2.
- LANES, 1: bits shifted per step; must satisfy 1 <= LANES < WIDTH.
- CNT_W, 4: width of the burst count; maximum burst is 2**CNT_W-1 steps.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous active-low reset.
- mode  in  3  step operation, encoding given under Behaviour.
- en  in  1  single manual step in IDLE.
- load  in  1  parallel load request in IDLE.
- load_data  in  WIDTH  parallel load value.
- start  in  1  burst request in IDLE.
- count  in  CNT_W  number of burst steps.
- sin  in  LANES  serial input lanes, sampled on every shifting edge.
- out  out  WIDTH  register contents.
- sout_l  out  LANES  out[WIDTH-1 -: LANES]; combinational from the register.
- sout_r  out  LANES  out[LANES-1:0]; combinational from the register.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: reset rstn, synchronous, active-low; clock clk. When rstn=0 at an edge:
  - out=0, busy=0, done=0, state=IDLE.
  - Reset overrides everything, including mid-burst; an aborted burst produces no done pulse.
- Mode encoding for one step with L=LANES:
  - 000 SHL: {out[W-L-1:0], sin}
  - 001 SHR: {sin, out[W-1:L]}
  - 010 ROL: {out[W-L-1:0], out[W-1:W-L]}
  - 011 ROR: {out[L-1:0], out[W-1:L]}
  - 100 ASR: {{L{out[W-1]}}, out[W-1:L]}
  - 101, 110, 111: hold
  - sin is ignored in the rotate and ASR modes.
- States: IDLE and BURST.
- IDLE, priority load > start > en > hold:
  - load=1: out <= load_data.
  - start=1, count>0: latch mode into mode_q and count into rem_q; go to BURST; busy=1 from the next cycle. No shift occurs on this edge.
  - start=1, count=0: no shift, stay in IDLE; done=1 for the next cycle only.
  - en=1: one step using the live mode.
- BURST:
  - Each edge performs one step using mode_q and the current sin, then decrements rem_q.
  - On the edge where rem_q=1, perform the last step, return to IDLE, set busy=0 and done=1 for exactly one cycle.
  - load, start, en and live mode are ignored while in BURST.
- Timing: start sampled at edge k with count=N gives:
  - shifts at edges k+1 through k+N
  - busy high from edge k to edge k+N
  - done high from edge k+N to edge k+N+1
- A start in the cycle where done=1 is accepted, giving back-to-back bursts.
- done is 0 in every other cycle.
- Outputs are registered except sout_l and sout_r.

Optional Feature:
Macro USRB_PARITY_EN.
- Defined: adds output parity (1 bit). It is registered and updated on the same edge as out, so it always equals ^out. It resets to 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Package usrb_pkg holds:
  - typedef enum logic [2:0] usrb_mode_t: SHL, SHR, ROL, ROR, ASR, HOLD
  - typedef enum logic usrb_state_t: IDLE, BURST
- One sub-module, usrb_step: a purely combinational next-value shifter with inputs (cur, mode, sin) and output nxt, parametrised by WIDTH and LANES.
- usrb_step is shared by the manual-step path and the burst path.

Test Plan:
- Reset and load: rstn=0 then load_data=8'hA5, load=1 -> out=8'h00 after reset; out=8'hA5 after the load edge; busy=0, done=0.
- Manual steps, W=8, L=1, out=8'h81: SHL with sin=0 -> 8'h02; ROR -> 8'hC0; ASR -> 8'hC0.
- Burst, W=8, L=2, load 8'h00, start with mode=SHL, count=3, sin=2'b11 -> busy high for 3 cycles, out=8'h3F, done high for exactly 1 cycle, aligned with busy falling.
- Corner cases:
  - count=0 -> done pulses with no shift and busy stays 0.
  - load and start asserted together -> the load wins and no burst starts.
  - en toggled during a burst -> ignored.
- Reset mid-burst: count=10, rstn=0 at the 4th shift -> out=0, busy=0, no done pulse.
- With USRB_PARITY_EN: load 8'h07 -> parity=1; ROL -> parity=1; load 8'h03 -> parity=0.
